// File: rtl/jtframe_objscan.sv
// Object scanner feeding the 16x16 sprite draw stage.
// On each hs rising edge it walks the object attribute table, selects the
// objects that cross the line being prepared and hands them one at a time to
// the draw stage. Request fields stay stable until the draw stage releases busy.
module jtframe_objscan #(
    parameter int CW = 12,
    parameter int PW = 8,
    parameter int OW = 7,
    parameter int AW = OW + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hs,
    input  logic [8:0]    vrender,
    output logic [AW-1:0] ram_addr,
    input  logic [15:0]   ram_data,
    output logic          draw,
    input  logic          busy,
    output logic [CW-1:0] code,
    output logic [8:0]    xpos,
    output logic [3:0]    ysub,
    output logic          hflip,
    output logic          vflip,
    output logic [PW-5:0] pal,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CHECK = 3'd2,
        ISSUE = 3'd3,
        HOLD  = 3'd4,
        NEXT  = 3'd5
    } state_t;

    state_t          state, state_nx;
    logic            hs_q;
    logic            hs_rise;
    logic [1:0]      cnt;
    logic [1:0]      word;
    logic [OW-1:0]   obj_idx;
    logic [8:0]      ypos_r;
    logic            vflip_r;
    logic            hflip_r;
    logic            hide_r;
    logic [CW-1:0]   code_r;
    logic [8:0]      xpos_r;
    logic [PW-5:0]   pal_r;
    logic            hold_first;
    logic [8:0]      ydiff;
    logic            visible;
    logic            last_obj;
    logic            unused_data;

    assign hs_rise  = hs & ~hs_q;
    // Word 3 is never addressed: the fourth READ cycle only collects w2 data.
    assign word     = (cnt == 2'd3) ? 2'd2 : cnt;
    assign ram_addr = {obj_idx, word};
    // Mod-512 distance from the object's top row; wraps naturally in 9 bits.
    assign ydiff    = vrender - ypos_r;
    assign visible  = ~hide_r && (ydiff[8:4] == 5'd0);
    assign last_obj = (obj_idx == {OW{1'b1}});
    // Reserved RAM bits are intentionally ignored.
    assign unused_data = ^ram_data;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; an hs rising edge restarts the scan from any state.
    always_comb begin
        state_nx = state;
        if (hs_rise) begin
            state_nx = READ;
        end else begin
            case (state)
                IDLE:    state_nx = IDLE;
                READ:    state_nx = (cnt == 2'd3) ? CHECK : READ;
                CHECK:   state_nx = visible ? ISSUE : NEXT;
                ISSUE:   state_nx = busy ? ISSUE : HOLD;
                HOLD:    state_nx = (!hold_first && !busy) ? NEXT : HOLD;
                NEXT:    state_nx = last_obj ? IDLE : READ;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Datapath: RAM capture, request fields, draw pulse, index and done flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q       <= 1'b0;
            cnt        <= 2'd0;
            obj_idx    <= '0;
            ypos_r     <= 9'd0;
            vflip_r    <= 1'b0;
            hflip_r    <= 1'b0;
            hide_r     <= 1'b0;
            code_r     <= '0;
            xpos_r     <= 9'd0;
            pal_r      <= '0;
            hold_first <= 1'b0;
            draw       <= 1'b0;
            code       <= '0;
            xpos       <= 9'd0;
            ysub       <= 4'd0;
            hflip      <= 1'b0;
            vflip      <= 1'b0;
            pal        <= '0;
            done       <= 1'b0;
        end else begin
            hs_q <= hs;
            draw <= 1'b0;
            if (hs_rise) begin
                obj_idx    <= '0;
                done       <= 1'b0;
                cnt        <= 2'd0;
                hold_first <= 1'b0;
            end else begin
                case (state)
                    READ: begin
                        cnt <= cnt + 2'd1;
                        case (cnt)
                            2'd1: begin
                                ypos_r  <= ram_data[8:0];
                                vflip_r <= ram_data[9];
                                hflip_r <= ram_data[10];
                                hide_r  <= ram_data[15];
                            end
                            2'd2: code_r <= ram_data[CW-1:0];
                            2'd3: begin
                                xpos_r <= ram_data[8:0];
                                pal_r  <= ram_data[9 +: PW-4];
                            end
                            default: ;
                        endcase
                    end
                    CHECK: begin
                        if (visible) begin
                            code  <= code_r;
                            xpos  <= xpos_r;
                            ysub  <= ydiff[3:0];
                            hflip <= hflip_r;
                            vflip <= vflip_r;
                            pal   <= pal_r;
                        end
                    end
                    ISSUE: begin
                        if (!busy) begin
                            draw       <= 1'b1;
                            hold_first <= 1'b1;
                        end
                    end
                    HOLD: hold_first <= 1'b0;
                    NEXT: begin
                        cnt <= 2'd0;
                        if (last_obj) begin
                            done <= 1'b1;
                        end else begin
                            obj_idx <= obj_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtframe_objscan.sv
// Self-checking bench for jtframe_objscan: a behavioural model builds the list
// of objects each scan must issue; a compare process checks every draw pulse,
// field stability while the draw stage is busy, and completion of the list.
module tb_jtframe_objscan;
    localparam int CW = 12, PW = 8, OW = 7, AW = 9, NOBJ = 128;

    logic          clk = 1'b0;
    logic          rst, hs, busy, draw, done, hflip, vflip;
    logic [8:0]    vrender, xpos;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_data;
    logic [CW-1:0] code;
    logic [3:0]    ysub;
    logic [PW-5:0] pal;

    always #5 clk = ~clk;

    jtframe_objscan #(.CW(CW), .PW(PW), .OW(OW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .hs(hs), .vrender(vrender), .ram_addr(ram_addr),
        .ram_data(ram_data), .draw(draw), .busy(busy), .code(code), .xpos(xpos),
        .ysub(ysub), .hflip(hflip), .vflip(vflip), .pal(pal), .done(done)
    );

    // Synchronous object RAM, one clock read latency
    logic [15:0] mem [0:4*NOBJ-1];
    always @(posedge clk) ram_data <= mem[ram_addr];

    typedef struct {
        logic [11:0] code;
        logic [8:0]  xpos;
        logic [3:0]  ysub;
        logic        hflip;
        logic        vflip;
        logic [3:0]  pal;
    } req_t;

    req_t expq[$];
    int   n_cmp = 0, n_err = 0;
    int   cyc = 0, ndraw = 0;
    int   draw_cyc[$];
    logic [11:0] last_code;
    logic [8:0]  last_xpos;
    logic [3:0]  last_ysub, last_pal;
    logic        last_hflip, last_vflip;
    logic        holding = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
    int   busy_min = 0, busy_max = 0;
    logic force_busy = 1'b0, rand_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every non-hidden object whose top row is 0..15 lines above vrender
    function automatic void build_queue();
        req_t e;
        expq.delete();
        for (int i = 0; i < NOBJ; i++) begin
            logic [15:0] w0, w1, w2;
            int yd;
            w0 = mem[4*i]; w1 = mem[4*i+1]; w2 = mem[4*i+2];
            yd = (int'(vrender) - int'(w0[8:0]) + 512) % 512;
            if (!w0[15] && yd < 16) begin
                e.code = w1[11:0]; e.xpos = w2[8:0]; e.ysub = yd[3:0];
                e.hflip = w0[10]; e.vflip = w0[9]; e.pal = w2[12:9];
                expq.push_back(e);
            end
        end
    endfunction

    // Compare process, sampled on the falling edge
    always @(negedge clk) begin
        req_t e;
        cyc++;
        if (rst) begin
            holding   = 1'b0;
            prev_done = 1'b0;
            prev_busy = busy;
        end else begin
            if (holding) begin
                chk("hold_code", code, last_code);
                chk("hold_xpos", xpos, last_xpos);
                chk("hold_ysub", ysub, last_ysub);
                chk("hold_pal", pal, last_pal);
                if (!busy) holding = 1'b0;
            end
            if (draw) begin
                chk("draw_needs_busy_low", prev_busy, 1'b0);
                chk("draw_expected", expq.size() > 0, 1'b1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("code", code, e.code);
                    chk("xpos", xpos, e.xpos);
                    chk("ysub", ysub, e.ysub);
                    chk("hflip", hflip, e.hflip);
                    chk("vflip", vflip, e.vflip);
                    chk("pal", pal, e.pal);
                end
                last_code = code; last_xpos = xpos; last_ysub = ysub;
                last_pal = pal; last_hflip = hflip; last_vflip = vflip;
                ndraw++;
                draw_cyc.push_back(cyc);
                holding = 1'b1;
            end
            if (done && !prev_done) chk("all_issued_at_done", expq.size(), 0);
            prev_busy = busy;
            prev_done = done;
        end
    end

    // Draw stage emulation: busy rises the cycle after draw
    initial begin
        int   rem = 0;
        logic d;
        busy = 1'b0;
        forever begin
            @(negedge clk); d = draw;
            @(posedge clk); #1;
            if (d) rem = $urandom_range(busy_max, busy_min);
            if (rem > 0) begin
                busy = 1'b1; rem--;
            end else begin
                busy = force_busy || (rand_busy && $urandom_range(0, 3) == 0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < NOBJ; i++) begin
            mem[4*i] = 16'h8000; mem[4*i+1] = 16'h0000;
            mem[4*i+2] = 16'h0000; mem[4*i+3] = 16'h0000;
        end
    endtask

    task automatic put(input int i, input logic [8:0] y, input logic vf, input logic hf,
                       input logic hide, input logic [11:0] c, input logic [8:0] x,
                       input logic [3:0] p);
        mem[4*i]   = {hide, 4'b0000, hf, vf, y};
        mem[4*i+1] = {4'b0000, c};
        mem[4*i+2] = {3'b000, p, x};
        mem[4*i+3] = 16'hDEAD;
    endtask

    task automatic start_scan();
        hs = 1'b1;
        step(1);
        build_queue();
        holding = 1'b0;
        chk("done_clear_on_hs", done, 1'b0);
        chk("restart_addr", ram_addr, 0);
        step(1);
        hs = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 30000) begin
            step(1); n++;
        end
        chk("done_reached", done, 1'b1);
    endtask

    task automatic wait_draws(input int target);
        int n = 0;
        while (ndraw < target && n < 5000) begin
            step(1); n++;
        end
        chk("draw_reached", ndraw >= target, 1'b1);
    endtask

    initial begin
        int n;
        logic [8:0] vtab [5];
        logic       htab [5];
        int         ctab [5];
        rst = 1'b1; hs = 1'b0; vrender = 9'd0;
        clear_mem();
        step(3);
        chk("rst_draw", draw, 1'b0);  chk("rst_done", done, 1'b0);
        chk("rst_addr", ram_addr, 0); chk("rst_code", code, 0);
        chk("rst_xpos", xpos, 0);     chk("rst_ysub", ysub, 0);
        chk("rst_flip", {hflip, vflip}, 2'b00); chk("rst_pal", pal, 0);
        rst = 1'b0;
        step(5);
        chk("idle_addr", ram_addr, 0); chk("idle_done", done, 1'b0);

        // Single object, busy never raised
        put(0, 9'h040, 1'b0, 1'b1, 1'b0, 12'h123, 9'h050, 4'h5);
        vrender = 9'h045; ndraw = 0;
        start_scan();
        wait_done(n);
        chk("scan_cycles", n, 770);
        chk("one_draw", ndraw, 1);
        chk("lit_code", last_code, 12'h123); chk("lit_xpos", last_xpos, 9'h050);
        chk("lit_ysub", last_ysub, 4'd5);    chk("lit_hflip", last_hflip, 1'b1);
        chk("lit_vflip", last_vflip, 1'b0);  chk("lit_pal", last_pal, 4'd5);
        step(20);
        chk("done_sticky", done, 1'b1);

        // Visibility boundaries
        vtab = '{9'h03F, 9'h050, 9'h045, 9'h040, 9'h04F};
        htab = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ctab = '{0, 0, 0, 1, 1};
        for (int k = 0; k < 5; k++) begin
            put(0, 9'h040, 1'b0, 1'b1, htab[k], 12'h123, 9'h050, 4'h5);
            vrender = vtab[k]; ndraw = 0;
            start_scan();
            wait_done(n);
            chk("boundary_draws", ndraw, ctab[k]);
        end
        put(0, 9'h1FC, 1'b1, 1'b0, 1'b0, 12'h0AB, 9'h1F0, 4'h3);
        vrender = 9'h002; ndraw = 0;
        start_scan();
        wait_done(n);
        chk("wrap_draws", ndraw, 1);
        chk("wrap_ysub", last_ysub, 4'd6);
        chk("wrap_vflip", last_vflip, 1'b1);

        // Busy held 20 cycles after each draw
        clear_mem();
        put(3, 9'h100, 1'b0, 1'b0, 1'b0, 12'h333, 9'h010, 4'h1);
        put(7, 9'h108, 1'b1, 1'b1, 1'b0, 12'h777, 9'h020, 4'h2);
        vrender = 9'h10A; busy_min = 20; busy_max = 20;
        ndraw = 0; draw_cyc.delete();
        start_scan();
        wait_done(n);
        chk("busy_draws", ndraw, 2);
        if (draw_cyc.size() == 2) chk("busy_gap", draw_cyc[1] - draw_cyc[0], 47);

        // Busy already high when an object is found
        clear_mem();
        put(0, 9'h020, 1'b0, 1'b0, 1'b0, 12'h055, 9'h030, 4'h4);
        vrender = 9'h025; busy_min = 0; busy_max = 0;
        force_busy = 1'b1; ndraw = 0;
        step(2);
        start_scan();
        step(30);
        chk("withheld_draws", ndraw, 0);
        force_busy = 1'b0;
        wait_done(n);
        chk("released_draws", ndraw, 1);

        // hs edge while idx 10 is held
        clear_mem();
        put(2, 9'h080, 1'b0, 1'b0, 1'b0, 12'h002, 9'h002, 4'h2);
        put(10, 9'h080, 1'b0, 1'b0, 1'b0, 12'h00A, 9'h00A, 4'hA);
        put(20, 9'h080, 1'b0, 1'b0, 1'b0, 12'h014, 9'h014, 4'h4);
        vrender = 9'h081; busy_min = 20; busy_max = 20; ndraw = 0;
        start_scan();
        wait_draws(2);
        chk("abort_point_code", last_code, 12'h00A);
        step(3);
        start_scan();
        wait_done(n);
        chk("restart_draws", ndraw, 5);
        chk("restart_last", last_code, 12'h014);

        // Reset while in HOLD
        clear_mem();
        put(0, 9'h080, 1'b0, 1'b0, 1'b0, 12'h0F0, 9'h0F0, 4'h7);
        ndraw = 0;
        start_scan();
        wait_draws(1);
        step(3);
        rst = 1'b1;
        step(1);
        chk("rst_hold_draw", draw, 1'b0); chk("rst_hold_done", done, 1'b0);
        chk("rst_hold_addr", ram_addr, 0);
        rst = 1'b0; expq.delete(); ndraw = 0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            chk("post_rst_idle_addr", ram_addr, 0);
        end
        chk("post_rst_no_draw", ndraw, 0);

        // Randomized scans, some restarted mid-way
        for (int s = 0; s < 8; s++) begin
            vrender = 9'($urandom);
            for (int i = 0; i < NOBJ; i++) begin
                logic [15:0] w0;
                w0 = 16'($urandom);
                if ($urandom_range(0, 1) == 1) w0[8:0] = vrender - 9'd20 + 9'($urandom_range(0, 40));
                w0[15] = ($urandom_range(0, 7) == 0);
                mem[4*i] = w0;
                mem[4*i+1] = 16'($urandom);
                mem[4*i+2] = 16'($urandom);
                mem[4*i+3] = 16'($urandom);
            end
            busy_min = 0; busy_max = $urandom_range(0, 6);
            rand_busy = (s % 2 == 1);
            start_scan();
            if (s % 3 == 1) begin
                step($urandom_range(50, 700));
                start_scan();
            end
            wait_done(n);
            chk("rand_all_issued", expq.size(), 0);
        end
        rand_busy = 1'b0;
        step(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/jtframe_objscan.md
Name: jtframe_objscan

Overview:
- Upstream feeder for the 16x16 sprite draw stage.
- On every horizontal sync it walks a synchronous object-attribute RAM and selects the objects that intersect the line being prepared.
- For each selected object it drives code/xpos/ysub/hflip/vflip/pal and issues a single-cycle draw request, respecting the draw stage's busy handshake.
- Inputs of the draw stage are assumed unlatched, so all request fields are held stable until busy drops.

Parameters:
- CW, 12, object code width (≤16)
- PW, 8, pixel width; palette field is PW-4 bits (PW-4 ≤ 6)
- OW, 7, object index width; table holds 2**OW entries
- AW, 9, RAM address width, fixed as OW+2

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- hs  in  1  horizontal sync; a rising edge starts a new scan
- vrender  in  9  line being prepared, already screen-flip corrected
- ram_addr  out  AW  object RAM address {obj_idx, word[1:0]}
- ram_data  in  16  RAM read data, valid one clock after ram_addr
- draw  out  1  one-cycle draw request
- busy  in  1  draw stage busy
- code  out  CW  object code
- xpos  out  9  horizontal position
- ysub  out  4  row within tile
- hflip  out  1  horizontal flip
- vflip  out  1  vertical flip
- pal  out  PW-4  palette
- done  out  1  high once the table has been fully scanned for the current line

Behaviour:
- Entry layout, 4 words per object:
  - w0: [8:0] ypos, [9] vflip, [10] hflip, [15] hide
  - w1: [CW-1:0] code
  - w2: [8:0] xpos, [9+PW-5:9] pal
  - w3: unused, never read
- Reset values: all outputs 0. State IDLE, obj_idx=0, done=0. hs edge detector cleared to 0.
- hs rising edge is detected from a registered copy of hs. In any state it forces obj_idx=0, done=0, draw=0 and moves to READ. An in-flight scan is aborted; the draw stage is not signalled.
- READ: issues w0, w1, w2 addresses on consecutive cycles. Data is captured one cycle after each address. An entry takes 4 cycles, then CHECK.
- CHECK, 1 cycle:
  - ydiff = (vrender - ypos) mod 512, 9-bit wraparound subtraction.
  - The object is visible iff hide=0 and ydiff[8:4]==0.
  - Visible: load outputs, with ysub=ydiff[3:0] (unflipped; vflip is passed separately). Go to ISSUE.
  - Not visible: go to NEXT.
- ISSUE: if busy=0, assert draw for exactly one cycle and go to HOLD. If busy=1, wait here with draw=0.
- HOLD: the first cycle is unconditional, covering busy's one-cycle rise latency. After that, remain while busy=1. When busy=0, go to NEXT. Output fields do not change from CHECK until leaving HOLD.
- NEXT: if obj_idx == 2**OW-1, set done=1 and go to IDLE. Otherwise increment obj_idx and go to READ.
- Objects are issued strictly in ascending index order. There is at most one outstanding request.
- ypos near the wrap point works through the mod-512 subtraction; e.g. ypos=0x1F8 is visible on lines 0x1F8–0x1FF and 0x000–0x007.
- hs edge coinciding with the draw cycle: the restart wins and draw is not asserted.
- done stays 1 until the next hs edge or rst.

Test Plan:
- Reset mid-scan (rst in HOLD) -> next cycle draw=0, done=0, ram_addr=0, idle until an hs rising edge.
- One object: idx0 ypos=0x040, code=0x123, xpos=0x050, pal=5, hflip=1; vrender=0x045; busy tied low -> exactly one draw with code=0x123, xpos=0x050, ysub=5, hflip=1, pal=5; done after 128 entries.
- Visibility boundaries: vrender=0x03F and 0x050 give no draw. hide=1 with vrender=0x045 gives no draw. ypos=0x1FC with vrender=0x002 gives a draw with ysub=6.
- Busy handshake: busy goes high the cycle after draw and stays high 20 cycles -> outputs stable through HOLD, no second draw until busy falls; next visible object issued after that.
- Busy already high when a visible object is found -> draw withheld in ISSUE until busy=0, then a single pulse.
- hs rising edge during HOLD of idx 10 -> scan restarts at idx0, ram_addr=0 on the next read cycle, idx 10 re-evaluated later, done=0.
